spi_bus_ctrl: RTL and testbench

- Memory-mapped front end for the SPI master on the laRVa peripheral bus.
- Buffers CPU writes in a TX FIFO and launches one spi_master transfer per entry.
- Captures each received word into an RX FIFO and drives the slave chip-select from a control register.
- Sits between the CPU bus decoder (upstream) and spi_master (downstream). Consumes spi_master's busy/dout; produces its wr/din/divider/bits.

---
 rtl/spi_bus_ctrl_pkg.sv | 34 +++
 rtl/spi_bus_ctrl_if.sv | 13 +
 rtl/spi_bus_ctrl_sync_fifo.sv | 44 ++++
 rtl/spi_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_bus_ctrl_pkg.sv
// Shared definitions for the SPI bus controller: register map, CTRL/STATUS
// bit positions, FSM states and the transfer-length helper.
package spi_bus_ctrl_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int unsigned CTRL_DIV_LSB   = 0;
    localparam int unsigned CTRL_BITS_LSB  = 8;
    localparam int unsigned CTRL_SS_BIT    = 16;
    localparam int unsigned CTRL_IRQEN_BIT = 17;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_FULL  = 2;
    localparam int unsigned STAT_RX_EMPTY = 3;
    localparam int unsigned STAT_ACTIVE   = 4;
    localparam int unsigned STAT_RX_OVF   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_CAPTURE
    } state_t;

    // Effective transfer length: 0 means 32; values above 32 are clamped to 32
    function automatic logic [5:0] eff_len(input logic [5:0] bits);
        return ((bits == 6'd0) || (bits > 6'd32)) ? 6'd32 : bits;
    endfunction

endpackage

// File: rtl/spi_bus_ctrl_if.sv
// CPU peripheral-bus side of the SPI controller.
interface spi_bus_ctrl_if;
    logic        sel;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport slave  (input sel, wr, rd, addr, wdata, output rdata, irq);
    modport master (output sel, wr, rd, addr, wdata, input rdata, irq);
endinterface

// File: rtl/spi_bus_ctrl_sync_fifo.sv
// Synchronous FIFO with MSB-compare full/empty; pushes when full and pops
// when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/spi_bus_ctrl.sv
// Memory-mapped front end for spi_master: TX/RX FIFOs, CTRL/STATUS
// registers and a transfer sequencer launching one transfer per TX entry.
module spi_bus_ctrl
    import spi_bus_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  DIV_RST    = 8'd15,
    parameter logic [5:0]  BITS_RST   = 6'd8
) (
    input  logic          clk,
    input  logic          resetb,
    spi_bus_ctrl_if.slave bus,
    output logic          spi_wr,
    output logic [31:0]   spi_din,
    output logic [7:0]    spi_divider,
    output logic [5:0]    spi_bits,
    input  logic          spi_busy,
    input  logic [31:0]   spi_dout,
    output logic          ss_n
);
    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic [5:0]  r_bits;
    logic        r_ss;
    logic        r_irq_en;
    logic        r_ovf;
    logic [31:0] r_din;
    logic [5:0]  r_len;

    logic        w_data_wr, w_data_rd, w_ctrl_wr, w_stat_wr;
    logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [31:0] w_tx_head, w_rx_head;
    logic        w_launch, w_capture, w_load;
    logic [5:0]  w_len;
    logic [31:0] w_rx_word;
    logic        w_active;

    assign w_data_wr = bus.sel & bus.wr & (bus.addr == REG_DATA);
    assign w_data_rd = bus.sel & bus.rd & (bus.addr == REG_DATA);
    assign w_ctrl_wr = bus.sel & bus.wr & (bus.addr == REG_CTRL);
    assign w_stat_wr = bus.sel & bus.wr & (bus.addr == REG_STATUS);

    assign w_launch  = (r_state == ST_LAUNCH);
    assign w_capture = (r_state == ST_CAPTURE);
    // Word and length are latched on the IDLE->LAUNCH edge so spi_din is valid alongside spi_wr
    assign w_load    = (r_state == ST_IDLE) & ~w_tx_empty;
    assign w_len     = eff_len(r_bits);
    assign w_rx_word = spi_dout & (32'hFFFF_FFFF >> (6'd32 - r_len));
    assign w_active  = (r_state != ST_IDLE) | ~w_tx_empty;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .i_push  (w_data_wr),
        .i_din   (bus.wdata),
        .i_pop   (w_launch),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .i_push  (w_capture),
        .i_din   (w_rx_word),
        .i_pop   (w_data_rd),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (!w_tx_empty) w_next = ST_LAUNCH;
            ST_LAUNCH:  w_next = ST_WAIT_HI;
            ST_WAIT_HI: if (spi_busy) w_next = ST_WAIT_LO;
            ST_WAIT_LO: if (!spi_busy) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_div    <= DIV_RST;
            r_bits   <= BITS_RST;
            r_ss     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_din    <= '0;
            r_len    <= 6'd32;
        end else begin
            if (w_ctrl_wr) begin
                r_div    <= bus.wdata[CTRL_DIV_LSB +: 8];
                r_bits   <= bus.wdata[CTRL_BITS_LSB +: 6];
                r_ss     <= bus.wdata[CTRL_SS_BIT];
                r_irq_en <= bus.wdata[CTRL_IRQEN_BIT];
            end
            if (w_capture && w_rx_full)
                r_ovf <= 1'b1;
            else if (w_stat_wr && bus.wdata[STAT_RX_OVF])
                r_ovf <= 1'b0;
            if (w_load) begin
                r_din <= w_tx_head << (6'd32 - w_len);
                r_len <= w_len;
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            REG_DATA:   bus.rdata = w_rx_empty ? 32'd0 : w_rx_head;
            REG_CTRL: begin
                bus.rdata[CTRL_DIV_LSB +: 8]  = r_div;
                bus.rdata[CTRL_BITS_LSB +: 6] = r_bits;
                bus.rdata[CTRL_SS_BIT]        = r_ss;
                bus.rdata[CTRL_IRQEN_BIT]     = r_irq_en;
            end
            REG_STATUS: begin
                bus.rdata[STAT_TX_FULL]  = w_tx_full;
                bus.rdata[STAT_TX_EMPTY] = w_tx_empty;
                bus.rdata[STAT_RX_FULL]  = w_rx_full;
                bus.rdata[STAT_RX_EMPTY] = w_rx_empty;
                bus.rdata[STAT_ACTIVE]   = w_active;
                bus.rdata[STAT_RX_OVF]   = r_ovf;
            end
            default:    bus.rdata = '0;
        endcase
    end

    assign bus.irq     = r_irq_en & (~w_rx_empty | r_ovf);
    assign spi_wr      = w_launch;
    assign spi_din     = r_din;
    assign spi_divider = r_div;
    assign spi_bits    = r_bits;
    assign ss_n        = ~r_ss;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl with a behavioural spi_master stand-in.
module tb_spi_bus_ctrl;
    localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_RSV = 2'd3;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        spi_wr, spi_busy, ss_n;
    logic [31:0] spi_din, spi_dout;
    logic [7:0]  spi_divider;
    logic [5:0]  spi_bits;

    int n_checks = 0;
    int n_fail   = 0;

    spi_bus_ctrl_if bus();

    spi_bus_ctrl #(.FIFO_DEPTH(4), .DIV_RST(8'd15), .BITS_RST(6'd8)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .bus         (bus),
        .spi_wr      (spi_wr),
        .spi_din     (spi_din),
        .spi_divider (spi_divider),
        .spi_bits    (spi_bits),
        .spi_busy    (spi_busy),
        .spi_dout    (spi_dout),
        .ss_n        (ss_n)
    );

    always #5 clk = ~clk;

    // Behavioural slave: busy for >=4 cycles after each spi_wr, then returns the next queued response
    logic [31:0] resp_q[$];
    logic [31:0] din_log[$];
    logic [31:0] s_resp;
    logic        s_stall = 1'b0;
    int          s_cnt = 0;
    int          cyc = 0;
    int          fall_cyc = -1;
    int          last_gap = -1;
    int          pulses = 0;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            spi_busy <= 1'b0;
            spi_dout <= '0;
            s_cnt     = 0;
            fall_cyc  = -1;
        end else begin
            cyc = cyc + 1;
            if (spi_wr) begin
                pulses = pulses + 1;
                din_log.push_back(spi_din);
                s_resp = (resp_q.size() > 0) ? resp_q.pop_front() : 32'd0;
                if (fall_cyc >= 0) last_gap = cyc - fall_cyc;
                fall_cyc  = -1;
                spi_busy <= 1'b1;
                s_cnt     = 3;
            end else if (spi_busy) begin
                if (s_cnt != 0) s_cnt = s_cnt - 1;
                else if (!s_stall) begin
                    spi_busy <= 1'b0;
                    spi_dout <= s_resp;
                    fall_cyc  = cyc;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.sel = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.rd = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.sel = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1 d = bus.rdata;
    endtask

    task automatic wait_done(input string nm);
        logic [31:0] st;
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            peek(A_STAT, st);
            if (!st[4] && !spi_busy) break;
        end
        check({nm, "_timeout"}, (i < 1000) ? 32'd0 : 32'd1, 32'd0);
    endtask

    task automatic wait_busy(input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_busy) break;
        end
        check({nm, "_timeout"}, (i < 200) ? 32'd0 : 32'd1, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] d;
        int p0;

        bus.sel = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.addr = A_DATA; bus.wdata = '0;
        vecs[0] = '{"rst_ctrl",     1'b0, A_CTRL, 32'h0,         32'h0000_080F};
        vecs[1] = '{"rst_status",   1'b0, A_STAT, 32'h0,         32'h0000_000A};
        vecs[2] = '{"ctrl_rw",      1'b1, A_CTRL, 32'h0002_0A55, 32'h0002_0A55};
        vecs[3] = '{"ctrl_mask",    1'b1, A_CTRL, 32'hFFFF_FFFF, 32'h0003_3FFF};
        vecs[4] = '{"rsv_read0",    1'b1, A_RSV,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5] = '{"data_rx_empty",1'b0, A_DATA, 32'h0,         32'h0000_0000};
        vecs[6] = '{"status_nopop", 1'b0, A_STAT, 32'h0,         32'h0000_000A};
        vecs[7] = '{"status_ro",    1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0000_000A};
        vecs[8] = '{"ctrl_zero",    1'b1, A_CTRL, 32'h0000_0000, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_spi_wr", {31'd0, spi_wr}, 32'd0);
        check("rst_spi_din", spi_din, 32'd0);
        resetb = 1'b1;
        @(negedge clk);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_divider", {24'd0, spi_divider}, 32'd15);
        check("rst_bits", {26'd0, spi_bits}, 32'd8);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
            if (i == 2) begin
                check("divider_from_ctrl", {24'd0, spi_divider}, 32'h55);
                check("bits_from_ctrl", {26'd0, spi_bits}, 32'h0A);
            end
            if (i == 3) check("ss_n_low", {31'd0, ss_n}, 32'd0);
        end
        check("no_spurious_wr", pulses, 0);

        // 8-bit transfer; slave returns extra high bits that must be masked off
        bus_write(A_CTRL, 32'h0001_0803);
        resp_q.push_back(32'h0001_233C);
        p0 = pulses;
        bus_write(A_DATA, 32'h0000_00A5);
        wait_done("xfer8");
        check("xfer8_pulses", pulses - p0, 1);
        check("xfer8_din", din_log[din_log.size()-1], 32'hA500_0000);
        check("xfer8_ss_n", {31'd0, ss_n}, 32'd0);
        check("xfer8_irq_off", {31'd0, bus.irq}, 32'd0);
        bus_read(A_DATA, d);
        check("xfer8_rx", d, 32'h0000_003C);

        // bits = 0 means 32: no shift, no mask
        bus_write(A_CTRL, 32'h0001_0000);
        resp_q.push_back(32'hFFFF_FFFF);
        bus_write(A_DATA, 32'h1234_5678);
        wait_done("xfer32");
        check("xfer32_din", din_log[din_log.size()-1], 32'h1234_5678);
        bus_read(A_DATA, d);
        check("xfer32_rx", d, 32'hFFFF_FFFF);
        check("xfer32_spi_bits_raw", {26'd0, spi_bits}, 32'd0);

        // Stalled slave: one word in flight, 4 queued, 6th dropped; 5 captures overflow RX
        bus_write(A_CTRL, 32'h0003_0808);
        for (int i = 0; i < 5; i++) resp_q.push_back(32'hA1 + i);
        din_log.delete();
        p0 = pulses;
        s_stall = 1'b1;
        bus_write(A_DATA, 32'h11);
        wait_busy("stall");
        for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h12 + i);
        @(negedge clk);
        peek(A_STAT, d);
        check("tx_full_status", d, 32'h0000_0019);
        bus_write(A_DATA, 32'h16);
        s_stall = 1'b0;
        wait_done("burst");
        check("burst_pulses", pulses - p0, 5);
        check("burst_log_size", din_log.size(), 5);
        for (int i = 0; i < 5 && i < din_log.size(); i++)
            check($sformatf("burst_din%0d", i), din_log[i], (32'h11 + i) << 24);
        check("b2b_gap", last_gap, 4);
        peek(A_STAT, d);
        check("ovf_status", d, 32'h0000_0026);
        check("ovf_irq", {31'd0, bus.irq}, 32'd1);
        bus_write(A_STAT, 32'h0000_0020);
        peek(A_STAT, d);
        check("ovf_cleared", d, 32'h0000_0006);
        check("irq_rx_nonempty", {31'd0, bus.irq}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_DATA, d);
            check($sformatf("rx_word%0d", i), d, 32'hA1 + i);
        end
        peek(A_STAT, d);
        check("rx_drained", d, 32'h0000_000A);
        check("irq_clear", {31'd0, bus.irq}, 32'd0);

        // Reset asserted while the FSM waits for busy to fall
        bus_write(A_CTRL, 32'h0001_0808);
        s_stall = 1'b1;
        bus_write(A_DATA, 32'h77);
        wait_busy("rst_mid");
        repeat (3) @(negedge clk);
        bus_write(A_DATA, 32'h78);
        p0 = pulses;
        @(negedge clk);
        resetb = 1'b0;
        #1;
        check("rst_mid_ss_n", {31'd0, ss_n}, 32'd1);
        peek(A_STAT, d);
        check("rst_mid_status", d, 32'h0000_000A);
        peek(A_CTRL, d);
        check("rst_mid_ctrl", d, 32'h0000_080F);
        s_stall = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_no_wr", pulses - p0, 0);
        peek(A_STAT, d);
        check("rst_mid_idle", d, 32'h0000_000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
